// File: rtl/pc_redirect_ctrl.sv
// Fetch-side redirect controller. It handles load-use stalls, redirects on taken transfers,
// squashes the wrong-path instruction, and keeps a circular return-address stack.
module pc_redirect_ctrl #(
  parameter int unsigned RAS_DEPTH    = 8,
  parameter int unsigned STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic        id_is_jmp,
  input  logic        id_is_call,
  input  logic        id_is_ret,
  input  logic        id_is_branch,
  input  logic        id_branch_taken,
  input  logic [15:0] id_npc,
  input  logic [2:0]  id_rs1,
  input  logic [2:0]  id_rs2,
  input  logic        ex_is_load,
  input  logic [2:0]  ex_rd,
  output logic [1:0]  PCsrc,
  output logic        kill,
  output logic        stall,
  output logic [15:0] ReturnAddress,
  output logic [4:0]  ras_count,
  output logic        ras_overflow,
  output logic        ras_underflow
);

  localparam int unsigned PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned RCNT_W  = 5;
  localparam int unsigned ADDR_W  = 16;

  localparam logic [1:0] SRC_SEQ = 2'b00;
  localparam logic [1:0] SRC_J   = 2'b01;
  localparam logic [1:0] SRC_I   = 2'b10;
  localparam logic [1:0] SRC_RA  = 2'b11;

  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]  r_ptr;
  logic [RCNT_W-1:0] r_count;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              r_squash;
  logic [1:0]        r_pcsrc;
  logic              r_kill;
  logic              r_stall;
  logic [ADDR_W-1:0] r_ret_addr;
  logic              r_overflow;
  logic              r_underflow;

  logic             w_hazard;
  logic             w_eval;
  logic             w_call;
  logic             w_ret;
  logic             w_br_taken;
  logic             w_xfer;
  logic             w_ras_full;
  logic             w_ras_empty;
  logic [PTR_W-1:0] w_top;

  // Decode the evaluated ID instruction. When call and ret are both set, it is treated as a call.
  always_comb begin
    w_hazard    = ex_is_load && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    w_eval      = id_valid && (r_stall_cnt == '0) && !r_squash;
    w_call      = id_is_call;
    w_ret       = id_is_ret && !id_is_call;
    w_br_taken  = id_is_branch && id_branch_taken;
    w_xfer      = id_is_jmp || w_call || w_ret || w_br_taken;
    w_ras_full  = (r_count == RCNT_W'(RAS_DEPTH));
    w_ras_empty = (r_count == '0);
    w_top       = PTR_W'(r_ptr - PTR_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) r_ras[i] <= '0;
      r_ptr       <= '0;
      r_count     <= '0;
      r_stall_cnt <= '0;
      r_squash    <= 1'b0;
      r_pcsrc     <= SRC_SEQ;
      r_kill      <= 1'b0;
      r_stall     <= 1'b0;
      r_ret_addr  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_kill   <= 1'b0;
      r_pcsrc  <= SRC_SEQ;
      r_squash <= 1'b0;
      if (r_stall_cnt != '0) begin
        // Counting down a load-use stall; ID is frozen and not evaluated.
        r_stall_cnt <= CNT_W'(r_stall_cnt - CNT_W'(1));
        r_stall     <= (r_stall_cnt != CNT_W'(1));
      end else if (w_eval && w_hazard) begin
        r_stall_cnt <= CNT_W'(STALL_CYCLES);
        r_stall     <= 1'b1;
      end else begin
        r_stall <= 1'b0;
        if (w_eval && w_xfer) begin
          r_kill   <= 1'b1;
          r_squash <= 1'b1;
          if (w_call) begin
            r_pcsrc      <= SRC_J;
            r_ras[r_ptr] <= id_npc;
            r_ptr        <= PTR_W'(r_ptr + PTR_W'(1));
            if (w_ras_full) r_overflow <= 1'b1;
            else            r_count    <= RCNT_W'(r_count + RCNT_W'(1));
          end else if (w_ret) begin
            r_pcsrc <= SRC_RA;
            if (w_ras_empty) begin
              r_ret_addr  <= '0;
              r_underflow <= 1'b1;
            end else begin
              r_ret_addr <= r_ras[w_top];
              r_ptr      <= w_top;
              r_count    <= RCNT_W'(r_count - RCNT_W'(1));
            end
          end else if (id_is_jmp) begin
            r_pcsrc <= SRC_J;
          end else begin
            r_pcsrc <= SRC_I;
          end
        end
      end
    end
  end

  assign PCsrc         = r_pcsrc;
  assign kill          = r_kill;
  assign stall         = r_stall;
  assign ReturnAddress = r_ret_addr;
  assign ras_count     = r_count;
  assign ras_overflow  = r_overflow;
  assign ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed self-checking bench for pc_redirect_ctrl (RAS_DEPTH=8, STALL_CYCLES=2).
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_is_jmp, id_is_call, id_is_ret, id_is_branch, id_branch_taken;
  logic [15:0] id_npc;
  logic [2:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_is_load;
  logic [1:0]  PCsrc;
  logic        kill, stall, ras_overflow, ras_underflow;
  logic [15:0] ReturnAddress;
  logic [4:0]  ras_count;

  int checks = 0;
  int errors = 0;

  pc_redirect_ctrl #(.RAS_DEPTH(8), .STALL_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_is_jmp(id_is_jmp),
    .id_is_call(id_is_call), .id_is_ret(id_is_ret), .id_is_branch(id_is_branch),
    .id_branch_taken(id_branch_taken), .id_npc(id_npc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .PCsrc(PCsrc), .kill(kill), .stall(stall),
    .ReturnAddress(ReturnAddress), .ras_count(ras_count), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic jmp, input logic call, input logic ret,
                        input logic br, input logic tk, input logic [15:0] npc);
    id_valid = 1'b1; id_is_jmp = jmp; id_is_call = call; id_is_ret = ret;
    id_is_branch = br; id_branch_taken = tk; id_npc = npc;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 16'h0000);
    id_rs1 = 3'd1; id_rs2 = 3'd2; ex_is_load = 1'b0; ex_rd = 3'd7;
  endtask

  task automatic do_reset();
    reset = 1'b1; idle(); step(); reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({PCsrc, kill, stall, ReturnAddress, ras_count, ras_overflow, ras_underflow} !== '0) begin
      errors++;
      $display("FAIL reset: PCsrc=%b kill=%b stall=%b RA=%h cnt=%0d ovf=%b unf=%b",
               PCsrc, kill, stall, ReturnAddress, ras_count, ras_overflow, ras_underflow);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle(); step();
      checks++;
      if (PCsrc !== 2'b00 || kill !== 1'b0 || stall !== 1'b0) begin
        errors++;
        $display("FAIL seq[%0d]: PCsrc=%b kill=%b stall=%b exp 00/0/0", i, PCsrc, kill, stall);
      end
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    set_id(0, 1, 0, 0, 0, 16'h0011); step();
    checks++;
    if (kill !== 1'b1 || PCsrc !== 2'b01 || ras_count !== 5'd1) begin
      errors++;
      $display("FAIL call: kill=%b PCsrc=%b cnt=%0d exp 1/01/1", kill, PCsrc, ras_count);
    end
    idle(); step();
    checks++;
    if (kill !== 1'b0 || PCsrc !== 2'b00) begin
      errors++;
      $display("FAIL call_next: kill=%b PCsrc=%b exp 0/00", kill, PCsrc);
    end
    idle(); step();
    set_id(0, 0, 1, 0, 0, 16'h0000); step();
    checks++;
    if (kill !== 1'b1 || PCsrc !== 2'b11 || ReturnAddress !== 16'h0011 || ras_count !== 5'd0) begin
      errors++;
      $display("FAIL ret: kill=%b PCsrc=%b RA=%h cnt=%0d exp 1/11/0011/0",
               kill, PCsrc, ReturnAddress, ras_count);
    end
    idle(); step(); idle(); step();
    checks++;
    if (ReturnAddress !== 16'h0011 || kill !== 1'b0) begin
      errors++;
      $display("FAIL ra_hold: RA=%h kill=%b exp 0011/0", ReturnAddress, kill);
    end
  endtask

  task automatic test_branch_not_taken();
    do_reset();
    set_id(0, 0, 0, 1, 0, 16'h0000); step();
    checks++;
    if (kill !== 1'b0 || PCsrc !== 2'b00) begin
      errors++;
      $display("FAIL br_nt: kill=%b PCsrc=%b exp 0/00", kill, PCsrc);
    end
  endtask

  task automatic test_hazard_defer();
    do_reset();
    set_id(0, 0, 0, 1, 1, 16'h0000);
    id_rs1 = 3'd0; id_rs2 = 3'd3; ex_is_load = 1'b1; ex_rd = 3'd3;
    step();
    ex_is_load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (stall !== 1'b1 || kill !== 1'b0) begin
        errors++;
        $display("FAIL haz_stall[%0d]: stall=%b kill=%b exp 1/0", i, stall, kill);
      end
      step();
    end
    checks++;
    if (stall !== 1'b0 || kill !== 1'b0) begin
      errors++;
      $display("FAIL haz_release: stall=%b kill=%b exp 0/0", stall, kill);
    end
    step();
    checks++;
    if (kill !== 1'b1 || PCsrc !== 2'b10 || stall !== 1'b0) begin
      errors++;
      $display("FAIL haz_branch: kill=%b PCsrc=%b stall=%b exp 1/10/0", kill, PCsrc, stall);
    end
    idle(); step();
    checks++;
    if (kill !== 1'b0 || PCsrc !== 2'b00) begin
      errors++;
      $display("FAIL haz_after: kill=%b PCsrc=%b exp 0/00", kill, PCsrc);
    end
  endtask

  task automatic test_squash();
    do_reset();
    set_id(1, 0, 0, 0, 0, 16'h0000); step();
    checks++;
    if (kill !== 1'b1 || PCsrc !== 2'b01) begin
      errors++;
      $display("FAIL jmp: kill=%b PCsrc=%b exp 1/01", kill, PCsrc);
    end
    set_id(0, 0, 1, 0, 0, 16'h0000); step();
    checks++;
    if (kill !== 1'b0 || PCsrc !== 2'b00 || ras_underflow !== 1'b0) begin
      errors++;
      $display("FAIL squash: kill=%b PCsrc=%b unf=%b exp 0/00/0", kill, PCsrc, ras_underflow);
    end
  endtask

  task automatic test_call_and_ret();
    do_reset();
    set_id(0, 1, 1, 0, 0, 16'h00AB); step();
    checks++;
    if (kill !== 1'b1 || PCsrc !== 2'b01 || ras_count !== 5'd1 || ras_underflow !== 1'b0) begin
      errors++;
      $display("FAIL call_ret: kill=%b PCsrc=%b cnt=%0d unf=%b exp 1/01/1/0",
               kill, PCsrc, ras_count, ras_underflow);
    end
  endtask

  task automatic test_overflow_underflow();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      set_id(0, 1, 0, 0, 0, 16'(i)); step();
      if (i == 8) begin
        checks++;
        if (ras_overflow !== 1'b0 || ras_count !== 5'd8) begin
          errors++;
          $display("FAIL fill8: ovf=%b cnt=%0d exp 0/8", ras_overflow, ras_count);
        end
      end
      idle(); step();
    end
    checks++;
    if (ras_overflow !== 1'b1 || ras_count !== 5'd8) begin
      errors++;
      $display("FAIL overflow: ovf=%b cnt=%0d exp 1/8", ras_overflow, ras_count);
    end
    for (int i = 0; i < 8; i++) begin
      set_id(0, 0, 1, 0, 0, 16'h0000); step();
      checks++;
      if (ReturnAddress !== 16'(9 - i) || kill !== 1'b1 || ras_count !== 5'(7 - i)) begin
        errors++;
        $display("FAIL pop[%0d]: RA=%h kill=%b cnt=%0d exp %h/1/%0d",
                 i, ReturnAddress, kill, ras_count, 16'(9 - i), 7 - i);
      end
      idle(); step();
    end
    set_id(0, 0, 1, 0, 0, 16'h0000); step();
    checks++;
    if (ReturnAddress !== 16'h0000 || ras_underflow !== 1'b1 || ras_count !== 5'd0 || ras_overflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow: RA=%h unf=%b cnt=%0d ovf=%b exp 0000/1/0/1",
               ReturnAddress, ras_underflow, ras_count, ras_overflow);
    end
    idle(); step();
  endtask

  task automatic test_reset_mid_stall();
    // Flags are still set from the previous test; a call makes the count nonzero.
    set_id(0, 1, 0, 0, 0, 16'h0042); step();
    idle(); step();
    id_rs1 = 3'd5; ex_is_load = 1'b1; ex_rd = 3'd5; step();
    ex_is_load = 1'b0; step();
    checks++;
    if (stall !== 1'b1 || ras_count !== 5'd1) begin
      errors++;
      $display("FAIL pre_rst: stall=%b cnt=%0d exp 1/1", stall, ras_count);
    end
    reset = 1'b1; step(); reset = 1'b0;
    checks++;
    if (stall !== 1'b0 || ras_count !== 5'd0 || ras_overflow !== 1'b0 || ras_underflow !== 1'b0 || kill !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_stall: stall=%b cnt=%0d ovf=%b unf=%b kill=%b exp 0/0/0/0/0",
               stall, ras_count, ras_overflow, ras_underflow, kill);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_sequential();
    test_call_ret();
    test_branch_not_taken();
    test_hazard_defer();
    test_squash();
    test_call_and_ret();
    test_overflow_underflow();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Control-side partner of the fetch stage. Consumes decoded control-transfer and hazard information from the ID/EX stages.
- Drives the fetch-stage controls PCsrc, kill, stall and ReturnAddress.
- Holds a circular return-address stack (RAS) for call/return.
- Resolves load-use hazards with a counted stall and suppresses wrong-path decisions after a redirect.

Parameters:
- RAS_DEPTH, 8, number of return-address entries (power of 2, 2..16).
- STALL_CYCLES, 1, stall length per load-use hazard (1..3).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_is_jmp  in  1  J-type jump in ID.
- id_is_call  in  1  J-type call in ID (pushes return address).
- id_is_ret  in  1  return in ID (pops RAS).
- id_is_branch  in  1  conditional branch in ID.
- id_branch_taken  in  1  branch condition true (valid with id_is_branch).
- id_npc  in  16  NPC of the ID instruction; this is the return address pushed by a call.
- id_rs1, id_rs2  in  3  source register numbers in ID.
- ex_is_load  in  1  EX holds a load.
- ex_rd  in  3  EX destination register.
- PCsrc  out  2  00 = sequential, 01 = J-target, 10 = I-target, 11 = ReturnAddress.
- kill  out  1  one-cycle redirect/squash pulse to fetch.
- stall  out  1  freeze PC and IF/ID.
- ReturnAddress  out  16  address for PCsrc = 11.
- ras_count  out  5  valid RAS entries (0..RAS_DEPTH).
- ras_overflow, ras_underflow  out  1  sticky error flags.

Behaviour:
- Reset: PCsrc = 00, kill = 0, stall = 0, ReturnAddress = 0, ras_count = 0, both sticky flags = 0, RAS pointer = 0, stall counter = 0, squash flag = 0. Reset mid-stall or mid-redirect aborts it; all outputs take reset values on the next edge.
- All outputs are registered. A decision made from inputs in cycle N appears on the outputs in cycle N+1.
- Evaluation gate: ID is evaluated only when id_valid = 1, stall counter = 0 and squash = 0.
- Priority within an evaluated cycle: load-use hazard > control transfer > sequential.
- Load-use hazard = ex_is_load && (ex_rd == id_rs1 || ex_rd == id_rs2).
  - On a hazard, the stall counter loads STALL_CYCLES and stall = 1 for exactly STALL_CYCLES cycles.
  - While the counter is nonzero, hazard and transfer inputs are ignored.
  - A control transfer present with the hazard is deferred, not lost: the instruction stays in ID and is re-evaluated after the stall.
- Taken transfer (jmp, call, ret, or branch with taken = 1) in cycle N:
  - Cycle N+1: kill = 1 and PCsrc = 01 for jmp/call, 10 for branch, 11 for ret.
  - Cycle N+1: squash = 1, so the wrong-path instruction then in ID is ignored.
  - Cycle N+2: kill = 0, PCsrc = 00, squash = 0.
  - kill is never high two consecutive cycles.
- Not-taken branch: no kill, PCsrc stays 00.
- Both id_is_call and id_is_ret high: treated as a call.
- RAS updates happen only for an accepted transfer, never for a deferred or squashed one.
- Call: push id_npc at top; ras_count saturates at RAS_DEPTH. Push when full overwrites the oldest entry (circular) and sets ras_overflow.
- Ret: ReturnAddress is registered from the top entry in the same edge that raises kill; the pointer then decrements and ras_count decrements.
- Pop when empty: ReturnAddress = 16'h0000, pointer/count unchanged, ras_underflow set.
- ReturnAddress holds its last value when no ret is accepted.
- Sticky flags clear only on reset.
- Pointer arithmetic is modulo RAS_DEPTH.

Test Plan:
- Reset, then id_valid = 1 with no control and no hazard for 5 cycles -> PCsrc = 00, kill = 0, stall = 0 throughout.
- Call with id_npc = 0x0011 at cycle 2, then (after squash cycle) ret at cycle 5 -> cycle 3: kill = 1, PCsrc = 01, ras_count = 1; cycle 6: kill = 1, PCsrc = 11, ReturnAddress = 0x0011, ras_count = 0.
- ex_is_load = 1, ex_rd = 3, id_rs2 = 3, id_is_branch = 1, taken = 1, STALL_CYCLES = 2 -> stall = 1 for 2 cycles with kill = 0; after the stall, kill = 1 and PCsrc = 10 for one cycle.
- Jump accepted, then the next cycle presents id_is_ret with RAS empty -> the ret is squashed: no second kill, ras_underflow stays 0.
- 9 calls with id_npc = 1..9, RAS_DEPTH = 8 -> ras_overflow = 1, ras_count = 8; 8 rets return 9, 8, ..., 2; a 9th ret -> ReturnAddress = 0, ras_underflow = 1.
- Assert reset during a stall (counter = 1) -> next cycle stall = 0, ras_count = 0, flags cleared.
